// File: rtl/sa_feeder.sv
// sa_feeder: transmit-side wavefront generator for the float16 systolic array.
// Buffers one A/B matrix pair (N k-slices) and replays it as the diagonally
// skewed DVO/DO wavefront, followed by DRAIN all-zero idle cycles.
// Optional build macro: SA_FEEDER_DBUF_EN adds a second A/B bank so that the
// next job can load while the current one is emitted.
//
// Handshake: a slice transfers on a rising edge where S_VALID && S_READY; the
// source holds S_DI stable while S_VALID is high and not yet accepted, and
// S_DI is ignored on any edge without a transfer.
module sa_feeder #(
  parameter int DIMENSION = 4,
  parameter int DRAIN     = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               S_VALID,
  output logic                               S_READY,
  input  logic [1:0][DIMENSION-1:0][15:0]    S_DI,
  output logic [DIMENSION-1:0]               DVO,
  output logic [1:0][DIMENSION-1:0][15:0]    DO,
  output logic                               BUSY,
  output logic                               DONE,
  output logic [1:0]                         o_dbg_state
);

  localparam int N     = DIMENSION;
  localparam int STEPS = 2 * N - 1;
  localparam int TW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam int DW    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
`ifdef SA_FEEDER_DBUF_EN
  localparam int NB    = 2;
`else
  localparam int NB    = 1;
`endif

  localparam logic [TW-1:0] T_LAST = TW'(STEPS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [DW-1:0] D_LAST = (DRAIN > 0) ? DW'(DRAIN - 1) : '0;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [TW-1:0]              r_t;
  logic [TW-1:0]              w_t_nxt;
  logic [KW-1:0]              r_slice;
  logic [DW-1:0]              r_drain;
  logic [NB-1:0]              r_full;
  logic [NB-1:0]              w_full_nxt;
  logic                       r_wr_bank;
  logic                       r_rd_bank;
  logic                       w_wr_bank_nxt;
  logic                       w_rd_bank_nxt;
  logic [15:0]                r_a [NB][N][N];  // r_a[bank][i][k] = A[i][k]
  logic [15:0]                r_b [NB][N][N];  // r_b[bank][k][j] = B[k][j]
  logic [N-1:0]               r_dvo;
  logic [1:0][N-1:0][15:0]    r_do;
  logic                       r_done;
  logic [N-1:0]               w_dvo_nxt;
  logic [1:0][N-1:0][15:0]    w_do_nxt;
  logic                       w_done_nxt;
  logic [KW-1:0]              w_k;
  logic                       w_s_ready;
  logic                       w_wr_en;
  logic                       w_fill;
  logic                       w_job_end;
  logic                       w_start;

`ifdef SA_FEEDER_DBUF_EN
  assign w_s_ready     = !r_full[r_wr_bank];
  assign w_wr_bank_nxt = r_wr_bank ^ w_fill;
  assign w_rd_bank_nxt = r_rd_bank ^ w_job_end;
`else
  assign w_s_ready     = (r_state == ST_LOAD);
  assign w_wr_bank_nxt = 1'b0;
  assign w_rd_bank_nxt = 1'b0;
`endif

  assign w_wr_en   = S_VALID && w_s_ready;
  assign w_fill    = w_wr_en && (r_slice == K_LAST);
  // A job ends on its last emit step when there is no drain, else on its last drain cycle.
  assign w_job_end = ((r_state == ST_EMIT) && (r_t == T_LAST) && (DRAIN == 0)) ||
                     ((r_state == ST_DRAIN) && (r_drain == D_LAST));
  // A new wavefront may start only from idle or exactly at the end of the previous job.
  assign w_start   = w_full_nxt[w_rd_bank_nxt] && ((r_state == ST_LOAD) || w_job_end);

  // Bank occupancy after this edge: the emitted bank frees at job end, the write bank fills on its last slice.
  always_comb begin
    w_full_nxt = r_full;
    if (w_job_end) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_fill)    w_full_nxt[r_wr_bank] = 1'b1;
  end

  // State register and step/drain counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_LOAD;
      r_t     <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_drain <= ((r_state == ST_DRAIN) && (w_state_nxt == ST_DRAIN)) ? r_drain + 1'b1 : '0;
    end
  end

  // Next-state logic: LOAD -> EMIT (2N-1 steps) -> DRAIN (DRAIN cycles) -> LOAD or next EMIT.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    case (r_state)
      ST_LOAD: begin
        if (w_start) begin
          w_state_nxt = ST_EMIT;
          w_t_nxt     = '0;
        end
      end
      ST_EMIT: begin
        if (r_t == T_LAST) begin
          w_t_nxt = '0;
          if (DRAIN > 0)    w_state_nxt = ST_DRAIN;
          else if (w_start) w_state_nxt = ST_EMIT;
          else              w_state_nxt = ST_LOAD;
        end else begin
          w_t_nxt = r_t + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drain == D_LAST) begin
          w_t_nxt     = '0;
          w_state_nxt = w_start ? ST_EMIT : ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
        w_t_nxt     = '0;
      end
    endcase
  end

  // Output logic: skewed operands for the step shown next cycle, bypassing a slice written on this edge.
  always_comb begin
    w_dvo_nxt  = '0;
    w_do_nxt   = '0;
    w_k        = '0;
    w_done_nxt = (w_state_nxt == ST_EMIT) && (w_t_nxt == T_LAST);
    if (w_state_nxt == ST_EMIT) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(w_t_nxt) >= i) && (int'(w_t_nxt) <= i + N - 1)) begin
          w_k          = KW'(N - 1 - (int'(w_t_nxt) - i));
          w_dvo_nxt[i] = 1'b1;
          if (w_wr_en && (r_wr_bank == w_rd_bank_nxt) && (r_slice == w_k)) begin
            w_do_nxt[0][i] = S_DI[0][i];
            w_do_nxt[1][i] = S_DI[1][i];
          end else begin
            w_do_nxt[0][i] = r_a[w_rd_bank_nxt][i][w_k];
            w_do_nxt[1][i] = r_b[w_rd_bank_nxt][w_k][i];
          end
        end
      end
    end
  end

  // Slice counter, bank flags and bank pointers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_slice   <= '0;
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_wr_en) r_slice <= (r_slice == K_LAST) ? '0 : r_slice + 1'b1;
      r_full    <= w_full_nxt;
      r_wr_bank <= w_wr_bank_nxt;
      r_rd_bank <= w_rd_bank_nxt;
    end
  end

  // Operand storage: slice k lands in column k of A and row k of B of the write bank.
  always_ff @(posedge CLK) begin
    if (!RST && w_wr_en) begin
      for (int i = 0; i < N; i++) begin
        r_a[r_wr_bank][i][r_slice] <= S_DI[0][i];
        r_b[r_wr_bank][r_slice][i] <= S_DI[1][i];
      end
    end
  end

  // Registered wavefront outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dvo  <= '0;
      r_do   <= '0;
      r_done <= 1'b0;
    end else begin
      r_dvo  <= w_dvo_nxt;
      r_do   <= w_do_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign S_READY     = w_s_ready;
  assign DVO         = r_dvo;
  assign DO          = r_do;
  assign DONE        = r_done;
  assign BUSY        = (r_state != ST_LOAD);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: self-checking bench for sa_feeder (N=4). A DRAIN=8 instance
// carries most scenarios; a DRAIN=0 instance covers the no-drain turnaround.
module tb_sa_feeder;

  localparam int N  = 4;
  localparam int DR = 8;
  localparam int NS = 2 * N - 1;
  localparam int EW = 1 + N + 2 * N * 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                       s_valid = 1'b0;
  logic                       s_ready;
  logic [1:0][N-1:0][15:0]    s_di = '0;
  logic [N-1:0]               dvo;
  logic [1:0][N-1:0][15:0]    dout;
  logic                       busy;
  logic                       done;
  logic [1:0]                 dbg;

  logic                       z_valid = 1'b0;
  logic                       z_ready;
  logic [1:0][N-1:0][15:0]    z_di = '0;
  logic [N-1:0]               z_dvo;
  logic [1:0][N-1:0][15:0]    z_dout;
  logic                       z_busy;
  logic                       z_done;
  logic [1:0]                 z_dbg;

  sa_feeder #(.DIMENSION(N), .DRAIN(DR)) dut (
    .CLK(clk), .RST(rst), .S_VALID(s_valid), .S_READY(s_ready), .S_DI(s_di),
    .DVO(dvo), .DO(dout), .BUSY(busy), .DONE(done), .o_dbg_state(dbg)
  );

  sa_feeder #(.DIMENSION(N), .DRAIN(0)) dut0 (
    .CLK(clk), .RST(rst), .S_VALID(z_valid), .S_READY(z_ready), .S_DI(z_di),
    .DVO(z_dvo), .DO(z_dout), .BUSY(z_busy), .DONE(z_done), .o_dbg_state(z_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int last_wait;
  int max_wait;
  int first_wait;
  int n_rdy_low;

  logic [15:0]             ma [2][N][N];   // ma[s][i][k] = A[i][k]
  logic [15:0]             mb [2][N][N];   // mb[s][k][j] = B[k][j]
  logic [N-1:0]            obs_dvo [NS];
  logic [1:0][N-1:0][15:0] obs_do  [NS];
  logic [EW-1:0]           exp_q [$];

  // Stimulus builders
  task automatic set_pattern(input int s);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[s][i][k] = {8'h1A, 4'(i + 1), 4'(k + 1)};
        mb[s][i][k] = {8'h1B, 4'(i + 1), 4'(k + 1)};
      end
  endtask

  task automatic set_random(input int s);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[s][i][k] = 16'($urandom);
        mb[s][i][k] = 16'($urandom);
      end
  endtask

  function automatic logic [1:0][N-1:0][15:0] slice_of(input int s, input int k);
    logic [1:0][N-1:0][15:0] v;
    for (int i = 0; i < N; i++) begin
      v[0][i] = ma[s][i][k];
      v[1][i] = mb[s][k][i];
    end
    return v;
  endfunction

  // Reference model: each A[i][k]/B[k][i] is scattered to lane i at step i+(N-1-k).
  task automatic build_expected(input int s);
    logic [N-1:0]            dv [NS];
    logic [1:0][N-1:0][15:0] d  [NS];
    logic                    dn;
    for (int t = 0; t < NS; t++) begin
      dv[t] = '0;
      d[t]  = '0;
    end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        dv[i + N - 1 - k][i]    = 1'b1;
        d[i + N - 1 - k][0][i]  = ma[s][i][k];
        d[i + N - 1 - k][1][i]  = mb[s][k][i];
      end
    for (int t = 0; t < NS; t++) begin
      dn = (t == NS - 1);
      exp_q.push_back({dn, dv[t], d[t]});
    end
    for (int c = 0; c < DR; c++) exp_q.push_back('0);
  endtask

  // Driver tasks
  task automatic wait_ready();
    last_wait = 0;
    @(negedge clk);
    while (!s_ready) begin
      last_wait++;
      if (last_wait > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_timeout got S_READY=0 for %0d cycles exp 1", last_wait);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic load_job(input int s, input int gap);
    int g;
    max_wait = 0;
    for (int k = 0; k < N; k++) begin
      g = (gap < 0) ? $urandom_range(0, 2) : ((k > 0) ? gap : 0);
      repeat (g) begin
        s_valid = 1'b0;
        s_di    = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_di    = slice_of(s, k);
      wait_ready();
      if (k == 0) first_wait = last_wait;
      if (last_wait > max_wait) max_wait = last_wait;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_di    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Scoreboard: compare one full job (emit + drain) against the model, starting in the t=0 cycle.
  task automatic check_wave(input int s, input string tag);
    logic [EW-1:0] e;
    build_expected(s);
    n_rdy_low = 0;
    for (int c = 0; c < NS + DR; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (c < NS) begin
        obs_dvo[c] = dvo;
        obs_do[c]  = dout;
      end
      n_checks++;
      if (dvo !== e[EW-2 -: N]) begin
        n_fail++;
        $display("FAIL %s_dvo c=%0d got=%b exp=%b", tag, c, dvo, e[EW-2 -: N]);
      end
      n_checks++;
      if (dout !== e[2*N*16-1:0]) begin
        n_fail++;
        $display("FAIL %s_do c=%0d got=%h exp=%h", tag, c, dout, e[2*N*16-1:0]);
      end
      n_checks++;
      if (done !== e[EW-1]) begin
        n_fail++;
        $display("FAIL %s_done c=%0d got=%b exp=%b", tag, c, done, e[EW-1]);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_busy c=%0d got=%b exp=1", tag, c, busy);
      end
`ifndef SA_FEEDER_DBUF_EN
      n_checks++;
      if (s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_ready c=%0d got=%b exp=0", tag, c, s_ready);
      end
`endif
      if (s_ready === 1'b0) n_rdy_low++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_spec_points(input string tag);
    n_checks++;
    if (obs_dvo[0] !== 4'b0001 || obs_do[0][0][0] !== 16'h1A14 || obs_do[0][1][0] !== 16'h1B41) begin
      n_fail++;
      $display("FAIL %s_t0 got dvo=%b a=%h b=%h exp dvo=0001 a=1a14 b=1b41", tag, obs_dvo[0], obs_do[0][0][0], obs_do[0][1][0]);
    end
    n_checks++;
    if (obs_dvo[3] !== 4'b1111 || obs_do[3][0] !== {16'h1A44, 16'h1A33, 16'h1A22, 16'h1A11} ||
        obs_do[3][1] !== {16'h1B44, 16'h1B33, 16'h1B22, 16'h1B11}) begin
      n_fail++;
      $display("FAIL %s_t3 got dvo=%b do=%h exp dvo=1111 diag", tag, obs_dvo[3], obs_do[3]);
    end
    n_checks++;
    if (obs_dvo[6] !== 4'b1000 || obs_do[6][0][3] !== 16'h1A41 || obs_do[6][1][3] !== 16'h1B14) begin
      n_fail++;
      $display("FAIL %s_t6 got dvo=%b a=%h b=%h exp dvo=1000 a=1a41 b=1b14", tag, obs_dvo[6], obs_do[6][0][3], obs_do[6][1][3]);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1 || dvo !== '0 || dout !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle got busy=%b rdy=%b dvo=%b done=%b do=%h exp 0 1 0 0 0", tag, busy, s_ready, dvo, done, dout);
    end
    @(posedge clk); #1;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");
  endtask

  task automatic test_basic();
    set_pattern(0);
    load_job(0, 0);
    check_wave(0, "basic");
    check_spec_points("basic");
    check_idle("basic_end");
  endtask

  task automatic test_gapped();
    set_pattern(0);
    load_job(0, 1);
    check_wave(0, "gapped");
    check_spec_points("gapped");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      set_random(0);
      load_job(0, -1);
      check_wave(0, "random");
    end
  endtask

  task automatic test_back_to_back();
    set_pattern(0);
    set_random(1);
    load_job(0, 0);
    s_valid = 1'b1;
    s_di    = slice_of(1, 0);
    check_wave(0, "bp_job1");
    n_checks++;
    if (n_rdy_low !== NS + DR) begin
      n_fail++;
      $display("FAIL bp_ready_low got=%0d exp=%0d", n_rdy_low, NS + DR);
    end
    load_job(1, 0);
    n_checks++;
    if (first_wait !== 0) begin
      n_fail++;
      $display("FAIL bp_first_accept got wait=%0d exp=0", first_wait);
    end
    check_wave(1, "bp_job2");
  endtask

  task automatic test_reset_mid();
    set_random(0);
    load_job(0, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (dvo !== 4'b0111) begin
      n_fail++;
      $display("FAIL rstmid_t2 got dvo=%b exp=0111", dvo);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1 || dvo !== '0 || dout !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after got busy=%b rdy=%b dvo=%b done=%b exp 0 1 0 0", busy, s_ready, dvo, done);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (dvo !== '0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_quiet c=%0d got dvo=%b done=%b busy=%b exp 0 0 0", c, dvo, done, busy);
      end
    end
    @(posedge clk); #1;
    set_random(1);
    load_job(1, 0);
    check_wave(1, "rstmid_fresh");
  endtask

  task automatic test_drain0();
    int cd, t0, k2, w;
    logic xfer;
    logic [N-1:0]  c0_dvo, t0_dvo;
    logic [15:0]   c0_a, t0_a, t0_b;
    set_pattern(0);
    set_random(1);
    for (int k = 0; k < N; k++) begin
      z_valid = 1'b1;
      z_di    = slice_of(0, k);
      w = 0;
      @(negedge clk);
      while (!z_ready && w < 100) begin
        w++;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    z_di = slice_of(1, 0);
    cd = -1; t0 = -1; k2 = 0;
    c0_dvo = '0; t0_dvo = '0; c0_a = '0; t0_a = '0; t0_b = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) begin
        c0_dvo = z_dvo;
        c0_a   = z_dout[0][0];
      end
      if (z_done === 1'b1 && cd < 0) cd = c;
      else if (cd >= 0 && t0 < 0 && z_dvo === 4'b0001) begin
        t0     = c;
        t0_dvo = z_dvo;
        t0_a   = z_dout[0][0];
        t0_b   = z_dout[1][0];
      end
      if (t0 >= 0) break;
      xfer = z_valid && z_ready;
      @(posedge clk); #1;
      if (xfer) begin
        k2++;
        if (k2 < N) z_di = slice_of(1, k2);
        else z_valid = 1'b0;
      end
    end
    z_valid = 1'b0;
    n_checks++;
    if (c0_dvo !== 4'b0001 || c0_a !== 16'h1A14) begin
      n_fail++;
      $display("FAIL d0_job1_t0 got dvo=%b a=%h exp 0001 1a14", c0_dvo, c0_a);
    end
    n_checks++;
    if (cd !== NS - 1) begin
      n_fail++;
      $display("FAIL d0_done_cycle got=%0d exp=%0d", cd, NS - 1);
    end
    n_checks++;
    if (t0 < 0 || (t0 - cd) !== N + 1) begin
      n_fail++;
      $display("FAIL d0_turnaround got=%0d exp=%0d", (t0 < 0) ? -1 : t0 - cd, N + 1);
    end
    n_checks++;
    if (t0_a !== ma[1][0][N-1] || t0_b !== mb[1][N-1][0]) begin
      n_fail++;
      $display("FAIL d0_job2_t0 got a=%h b=%h exp a=%h b=%h", t0_a, t0_b, ma[1][0][N-1], mb[1][N-1][0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dbuf();
    set_pattern(0);
    set_random(1);
    load_job(0, 0);
    fork
      check_wave(0, "dbuf_job1");
      begin
        load_job(1, 0);
        n_checks++;
        if (max_wait !== 0) begin
          n_fail++;
          $display("FAIL dbuf_overlap_ready got max_wait=%0d exp=0", max_wait);
        end
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL dbuf_both_full got S_READY=%b exp=0", s_ready);
        end
      end
    join
    fork
      check_wave(1, "dbuf_job2");
      begin
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL dbuf_bank_freed got S_READY=%b exp=1", s_ready);
        end
      end
    join
  endtask

  // Time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_random();
`ifndef SA_FEEDER_DBUF_EN
    test_back_to_back();
`endif
    test_reset_mid();
`ifndef SA_FEEDER_DBUF_EN
    test_drain0();
`else
    test_dbuf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
